// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, FSM state type and opcode screen for alu_arbiter
// Contents: ALUOp constants, Beta compare selects, state_t, op_supported().
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [2:0] BETA_BLT = 3'b100;
  localparam logic [2:0] BETA_BGE = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_supported = 1'b1;
      default:                               op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker
// Ports: valid[1:0] requests in, last_grant (1 = requester 1 won last), grant[1:0] one-hot out.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention goes to whoever did not win most recently.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one single-cycle ALU between two requesters
// Ports: clk, rst_n (async, active low); req_valid/req_ready[1:0] with per-requester
// a/b/op/beta payload; resp_valid/resp_ready[1:0] with shared resp_result/zero/err;
// alu_a/b/op/beta drive to the external ALU and alu_result/alu_zero back from it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [2:0]       req_beta0,
  input  logic [2:0]       req_beta1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [2:0]       alu_beta,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_t           state, next_state;
  logic             last_grant;
  logic             grant_id;
  logic [1:0]       grant;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [2:0]       beta_q;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept = (state == ST_IDLE) && rst_n && (|(req_valid & grant));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = 4'b0000;
    alu_beta   = 3'b000;
    case (state)
      ST_IDLE: begin
        // Gated by rst_n so nothing is offered while reset is held.
        if (rst_n) req_ready = grant;
        if (accept) next_state = ST_EXEC;
      end
      ST_EXEC: begin
        alu_a    = a_q;
        alu_b    = b_q;
        // Unsupported opcodes still run as ADD; the captured result is discarded.
        alu_op   = op_supported(op_q) ? op_q : OP_ADD;
        alu_beta = beta_q;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[grant_id] = 1'b1;
        if (resp_ready[grant_id]) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'b0000;
      beta_q      <= 3'b000;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        grant_id   <= grant[1];
        last_grant <= grant[1];
        a_q        <= grant[1] ? req_a1    : req_a0;
        b_q        <= grant[1] ? req_b1    : req_b0;
        op_q       <= grant[1] ? req_op1   : req_op0;
        beta_q     <= grant[1] ? req_beta1 : req_beta0;
      end
      if (state == ST_EXEC) begin
        if (op_supported(op_q)) begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_err    <= 1'b0;
        end else begin
          resp_result <= '0;
          resp_zero   <= 1'b0;
          resp_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] req_a0, req_a1, req_b0, req_b1;
  logic [3:0]  req_op0, req_op1, alu_op;
  logic [2:0]  req_beta0, req_beta1, alu_beta;
  logic [63:0] resp_result, alu_a, alu_b, alu_result;
  logic        resp_zero, resp_err, alu_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .req_beta0(req_beta0), .req_beta1(req_beta1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_beta(alu_beta),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Behavioural stand-in for the external 64-bit ALU.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 64'd0;
    endcase
    if (alu_beta == 3'b100)      alu_zero = (alu_a < alu_b);
    else if (alu_beta == 3'b101) alu_zero = (alu_a >= alu_b);
    else                         alu_zero = (alu_result == 64'd0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit r, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [2:0] beta);
    if (!r) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_beta0 = beta;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_beta1 = beta;
    end
    req_valid[r] = 1'b1;
  endtask

  task automatic run_op(input string tag, input bit r, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input logic [2:0] beta, input logic [3:0] exp_alu_op,
                        input logic [63:0] exp_res, input logic exp_zero, input logic exp_err);
    logic [1:0] onehot;
    onehot = r ? 2'b10 : 2'b01;
    set_req(r, a, b, op, beta);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(onehot));
    step();
    req_valid[r] = 1'b0;
    chk({tag, "_alu_op"}, 64'(alu_op), 64'(exp_alu_op));
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_beta"}, 64'(alu_beta), 64'(beta));
    step();
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(onehot));
    chk({tag, "_result"}, resp_result, exp_res);
    chk({tag, "_zero"}, 64'(resp_zero), 64'(exp_zero));
    chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
    resp_ready = onehot;
    step();
    resp_ready = 2'b00;
    chk({tag, "_idle"}, 64'(resp_valid), 64'(2'b00));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_op0 = '0; req_op1 = '0; req_beta0 = '0; req_beta1 = '0;

    // Reset with both requests already pending.
    set_req(0, 64'd10, 64'd3, 4'b0110, 3'b000);
    set_req(1, 64'hF0, 64'h0F, 4'b0001, 3'b000);
    step(); step();
    chk("rst_req_ready", 64'(req_ready), 64'(2'b00));
    chk("rst_resp_valid", 64'(resp_valid), 64'(2'b00));
    chk("rst_result", resp_result, 64'd0);
    chk("rst_zero", 64'(resp_zero), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_alu_beta", 64'(alu_beta), 64'd0);

    // Contention: req0 first, then req1.
    rst_n = 1'b1;
    #1;
    chk("cont_ready0", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    chk("cont_exec_ready", 64'(req_ready), 64'(2'b00));
    chk("cont_alu_op0", 64'(alu_op), 64'(4'b0110));
    chk("cont_alu_a0", alu_a, 64'd10);
    step();
    chk("cont_resp_valid0", 64'(resp_valid), 64'(2'b01));
    chk("cont_result0", resp_result, 64'd7);
    chk("cont_zero0", 64'(resp_zero), 64'd0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("cont_idle_valid", 64'(resp_valid), 64'(2'b00));
    chk("cont_ready1", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    chk("cont_alu_op1", 64'(alu_op), 64'(4'b0001));
    step();
    chk("cont_resp_valid1", 64'(resp_valid), 64'(2'b10));
    chk("cont_result1", resp_result, 64'hFF);
    resp_ready = 2'b01;
    step();
    chk("wrong_ready_ignored", 64'(resp_valid), 64'(2'b10));
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;
    chk("cont_done", 64'(resp_valid), 64'(2'b00));

    // Second contention goes to req0 again; then a single ADD from req0.
    set_req(0, 64'd5, 64'd7, 4'b0010, 3'b000);
    set_req(1, 64'd1, 64'd1, 4'b0010, 3'b000);
    #1;
    chk("cont2_ready", 64'(req_ready), 64'(2'b01));
    req_valid[1] = 1'b0;
    step();
    req_valid[0] = 1'b0;
    chk("add_alu_op", 64'(alu_op), 64'(4'b0010));
    chk("add_alu_a", alu_a, 64'd5);
    chk("add_alu_b", alu_b, 64'd7);
    step();
    chk("add_resp_valid", 64'(resp_valid), 64'(2'b01));
    chk("add_result", resp_result, 64'd12);
    chk("add_zero", 64'(resp_zero), 64'd0);
    chk("add_err", 64'(resp_err), 64'd0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;

    // Backpressure on a NOR of 0,0 while req1 waits.
    set_req(0, 64'd0, 64'd0, 4'b1100, 3'b000);
    #1;
    chk("bp_ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    set_req(1, 64'd1, 64'd1, 4'b0010, 3'b000);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 64'(resp_valid), 64'(2'b01));
      chk("bp_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("bp_req_ready", 64'(req_ready), 64'(2'b00));
      if (i < 4) step();
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("bp_idle_valid", 64'(resp_valid), 64'(2'b00));
    chk("bp_idle_ready", 64'(req_ready), 64'(2'b10));
    step();
    req_valid[1] = 1'b0;
    step();
    chk("bp_next_valid", 64'(resp_valid), 64'(2'b10));
    chk("bp_next_result", resp_result, 64'd2);
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;

    // Branch flag and illegal opcodes.
    run_op("blt", 1'b0, 64'd3, 64'd9, 4'b0110, 3'b100, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0);
    run_op("bge", 1'b0, 64'd3, 64'd9, 4'b0110, 3'b101, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
    run_op("nobr", 1'b0, 64'd3, 64'd9, 4'b0110, 3'b000, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
    run_op("and", 1'b1, 64'hF0F0, 64'h0FF0, 4'b0000, 3'b000, 4'b0000, 64'h00F0, 1'b0, 1'b0);
    run_op("ill", 1'b1, 64'd5, 64'd6, 4'b1111, 3'b000, 4'b0010, 64'd0, 1'b0, 1'b1);
    run_op("ill_br", 1'b1, 64'd3, 64'd9, 4'b0111, 3'b100, 4'b0010, 64'd0, 1'b0, 1'b1);

    // Reset during EXEC discards the operation and restores last_grant.
    set_req(0, 64'd5, 64'd7, 4'b0010, 3'b000);
    #1;
    step();
    req_valid[0] = 1'b0;
    chk("mid_exec_op", 64'(alu_op), 64'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
    chk("mid_rst_alu_a", alu_a, 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(2'b00));
    chk("mid_rst_err", 64'(resp_err), 64'd0);
    step();
    chk("mid_rst_hold", 64'(resp_valid), 64'(2'b00));
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 64'(resp_valid), 64'(2'b00));
    chk("post_rst_result", resp_result, 64'd0);
    set_req(0, 64'd1, 64'd2, 4'b0010, 3'b000);
    set_req(1, 64'd3, 64'd4, 4'b0010, 3'b000);
    #1;
    chk("post_rst_contention", 64'(req_ready), 64'(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares the single-cycle 64-bit ALU between two independent clients, for example the issue stage and a branch/address unit. It sequences each granted operation through a three-state FSM: accept, execute, respond. It registers operands into the ALU and captures Result/Zero into a held response with a valid/ready handshake. It also screens opcodes the ALU does not implement, so a stale Result can never be returned to a client.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must match the ALU datapath.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a0, req_a1  in  WIDTH  operand a for requester 0/1.
- req_b0, req_b1  in  WIDTH  operand b.
- req_op0, req_op1  in  4  ALUOp code.
- req_beta0, req_beta1  in  3  branch-compare select (100 = BLT, 101 = BGE).
- resp_valid  out  2  response valid, one-hot to the granted requester.
- resp_ready  in  2  per-requester response accept.
- resp_result  out  WIDTH  captured result, shared by both requesters.
- resp_zero  out  1  captured Zero/branch flag.
- resp_err  out  1  opcode was unsupported; result and zero forced to 0.
- alu_a, alu_b  out  WIDTH  ALU operand drive.
- alu_op  out  4  ALU opcode drive.
- alu_beta  out  3  ALU Beta drive.
- alu_result  in  WIDTH  ALU Result (combinational).
- alu_zero  in  1  ALU Zero (combinational).

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Winner is the single valid requester.
  - If both are valid, the winner is the requester not granted most recently. last_grant resets to 1, so requester 0 wins the first contention.
  - req_ready[winner] = 1 combinationally; the other bit is 0. Both bits are 0 outside IDLE.
  - On valid&ready: latch a/b/op/beta and grant id, update last_grant, go to EXEC.
- EXEC (exactly one cycle):
  - alu_* driven from the operand registers.
  - At clock end, capture alu_result/alu_zero into the response registers and go to RESP.
- Supported opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
- Any other opcode: alu_op is driven 0010, the captured result and zero are 0, and resp_err = 1.
- Zero/beta is passed through unmodified. The ALU computes the BLT/BGE compare as unsigned.
- RESP:
  - resp_valid[grant] = 1; result, zero and err stay stable until resp_ready[grant].
  - resp_ready on the non-granted bit is ignored.
  - On the handshake, go to IDLE; no new request is accepted in the same cycle.
- Requests may hold valid through EXEC/RESP. They are not dropped and compete again in IDLE.

## Timing
- Reset values:
  - state IDLE, last_grant 1.
  - req_ready 00, resp_valid 00.
  - resp_result 0, resp_zero 0, resp_err 0.
  - alu_a 0, alu_b 0, alu_op 0000, alu_beta 000.
- alu_* outputs are 0 in IDLE and RESP; they are nonzero only in EXEC.
- Latency: accept at cycle N, EXEC at N+1, resp_valid high at N+2.
- Minimum occupancy is 3 cycles per operation, so peak throughput is one operation per 3 cycles.
- resp_ready high at N+2 gives IDLE at N+3, and the next accept can occur at N+3.
- rst_n assertion in any state clears everything immediately; an in-flight operation is discarded with no response.
- Requesters must hold payload stable while valid and not ready.

## Structure
- Shared package alu_pkg holds:
  - ALUOp constants AND/OR/ADD/SUB/NOR.
  - Beta constants BLT/BGE.
  - The state enum typedef.
  - The function op_supported(op).
- Sub-module rr_arb2: a two-input round-robin picker (valid[1:0], last_grant → grant one-hot). Everything else is flat.
- alu_arbiter instantiates ALU_64_bit at the integration level, not inside this block.

## Test plan
- Single op: req0 issues ADD a=5, b=7. Expect req_ready[0] at N, alu_op=0010 at N+1, resp_valid=01 at N+2, result 12, zero 0, err 0.
- Contention: both valid from reset, req0 SUB 10−3 and req1 OR F0|0F. Expect req0 served first with result 7, then req1 with result FF; the next contention grants req0 again.
- Backpressure: hold resp_ready=0 for 5 cycles after a NOR of 0,0. Expect result FFFF_FFFF_FFFF_FFFF stable for all 5 cycles, req_ready=00, and IDLE one cycle after resp_ready.
- Branch flag: beta=100, a=3, b=9 gives zero 1; beta=101 with the same operands gives zero 0; beta=000 gives zero 0.
- Illegal op: op=1111 gives err 1, result 0, zero 0.
- Reset mid-EXEC: pulse rst_n low during EXEC. Expect resp_valid never asserted, all outputs at reset values, and req0 winning the next contention.
